uart_frame_arbiter: RTL and testbench

- Shares the single uart_tx transmitter between two 32-bit word sources.
- Channel A is the FIR result path: async_fifo read side, clk domain.
- Channel B is a status/telemetry path with a valid/ready handshake, e.g. coefficient readback or sample counters.
- Each word is serialised as a framed byte burst. Arbitration is per frame, with a bounded A-burst so B is never starved by continuous FIR output.

---
 rtl/uart_frame_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_frame_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_arbiter.sv
// Per-frame arbiter sharing one uart_tx between a FIFO word source (A) and a valid/ready source (B).
// Optional checksum byte when UART_FRAME_CHKSUM_EN is defined.
module uart_frame_arbiter #(
  parameter logic [7:0]  HDR_A       = 8'h49,
  parameter logic [7:0]  HDR_B       = 8'h53,
  parameter int unsigned MAX_A_BURST = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_a_empty,
  output logic                 o_a_rd_en,
  input  logic [31:0]          i_a_data,
  input  logic                 i_b_valid,
  input  logic [31:0]          i_b_data,
  output logic                 o_b_ready,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_send,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_frame_cnt_a,
  output logic [CNT_WIDTH-1:0] o_frame_cnt_b
);

`ifdef UART_FRAME_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 6;
`else
  localparam int unsigned FRAME_LEN = 5;
`endif
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_A_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_FETCH, S_LATCH, S_SEND, S_WAIT, S_DONE
  } state_t;

  state_t               state, state_nx;
  logic [31:0]          word_q;
  logic                 grant_b_q;
  logic [2:0]           idx_q;
  logic [7:0]           burst_q;
  logic [7:0]           byte_q;
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_b_q;

  logic       b_win, a_win;
  logic       take_a, take_b;
  logic       send_now, byte_done, frame_end;
  logic [7:0] hdr, cur_byte;

  // B preempts only when A is empty or A has used up its burst allowance
  assign b_win = i_b_valid && (i_a_empty || (burst_q >= BURST_MAX));
  assign a_win = !b_win && !i_a_empty;
  assign hdr   = grant_b_q ? HDR_B : HDR_A;

  always_comb begin
    cur_byte = hdr;
    case (idx_q)
      3'd1:    cur_byte = word_q[31:24];
      3'd2:    cur_byte = word_q[23:16];
      3'd3:    cur_byte = word_q[15:8];
      3'd4:    cur_byte = word_q[7:0];
`ifdef UART_FRAME_CHKSUM_EN
      3'd5:    cur_byte = hdr ^ word_q[31:24] ^ word_q[23:16] ^ word_q[15:8] ^ word_q[7:0];
`endif
      default: cur_byte = hdr;
    endcase
  end

  always_comb begin
    state_nx  = state;
    o_a_rd_en = 1'b0;
    o_b_ready = 1'b0;
    take_a    = 1'b0;
    take_b    = 1'b0;
    send_now  = 1'b0;
    byte_done = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      S_IDLE:
        if (i_enable && (!i_a_empty || i_b_valid)) state_nx = S_ARB;
      S_ARB:
        if (!i_enable) begin
          state_nx = S_IDLE;
        end else if (b_win) begin
          take_b    = 1'b1;
          o_b_ready = 1'b1;
          state_nx  = S_SEND;
        end else if (a_win) begin
          take_a   = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_IDLE;
        end
      S_FETCH: begin
        o_a_rd_en = 1'b1;
        state_nx  = S_LATCH;
      end
      S_LATCH:
        state_nx = S_SEND;
      S_SEND:
        // leaving SEND right away keeps the strobe to a single cycle
        if (!i_tx_active) begin
          send_now = 1'b1;
          state_nx = S_WAIT;
        end
      S_WAIT:
        if (i_tx_done) begin
          byte_done = 1'b1;
          if (idx_q == LAST_IDX) begin
            frame_end = 1'b1;
            state_nx  = S_DONE;
          end else begin
            state_nx  = S_SEND;
          end
        end
      S_DONE:
        state_nx = i_enable ? S_ARB : S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      word_q    <= '0;
      grant_b_q <= 1'b0;
      idx_q     <= '0;
      burst_q   <= '0;
      byte_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
    end else begin
      state <= state_nx;
      if (take_b) begin
        grant_b_q <= 1'b1;
        word_q    <= i_b_data;
        burst_q   <= '0;
      end
      if (take_a) begin
        grant_b_q <= 1'b0;
        if (burst_q < BURST_MAX) burst_q <= burst_q + 8'd1;
      end
      if (state == S_LATCH) word_q <= i_a_data;
      if (send_now)         byte_q <= cur_byte;
      if (byte_done)        idx_q  <= idx_q + 3'd1;
      if (state == S_DONE)  idx_q  <= '0;
      if (frame_end) begin
        if (grant_b_q) cnt_b_q <= cnt_b_q + 1'b1;
        else           cnt_a_q <= cnt_a_q + 1'b1;
      end
    end
  end

  // last sent byte stays on the bus between sends
  assign o_tx_byte     = send_now ? cur_byte : byte_q;
  assign o_tx_send     = send_now;
  assign o_busy        = (state != S_IDLE);
  assign o_frame_cnt_a = cnt_a_q;
  assign o_frame_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: FIFO / handshake / uart_tx models, frame-order reference model.
module tb_uart_frame_arbiter;
  localparam int MAXB     = 3;
  localparam int CW       = 3;
  localparam int BYTE_CYC = 4;
  localparam int LIM      = 4000;
`ifdef UART_FRAME_CHKSUM_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif
  localparam logic [7:0] HA = 8'h49;
  localparam logic [7:0] HB = 8'h53;

  logic          i_clk = 1'b0, i_rst = 1'b1, i_enable = 1'b0, i_a_empty = 1'b1;
  logic          i_b_valid = 1'b0, i_tx_active = 1'b0, i_tx_done = 1'b0;
  logic [31:0]   i_a_data = '0, i_b_data = '0;
  logic          o_a_rd_en, o_b_ready, o_tx_send, o_busy;
  logic [7:0]    o_tx_byte;
  logic [CW-1:0] o_frame_cnt_a, o_frame_cnt_b;

  always #5 i_clk = ~i_clk;

  uart_frame_arbiter #(.HDR_A(HA), .HDR_B(HB), .MAX_A_BURST(MAXB), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_a_empty(i_a_empty),
    .o_a_rd_en(o_a_rd_en), .i_a_data(i_a_data), .i_b_valid(i_b_valid), .i_b_data(i_b_data),
    .o_b_ready(o_b_ready), .o_tx_byte(o_tx_byte), .o_tx_send(o_tx_send),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_frame_cnt_a(o_frame_cnt_a), .o_frame_cnt_b(o_frame_cnt_b));

  int total = 0, bad = 0;
  logic [31:0] a_q[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_q[$];
  int  cyc = 0, rd_cnt = 0, rdy_cnt = 0, clash = 0, wide = 0;
  int  done_cyc = -1, min_gap = 1000000, hold_len = 0, busy_cnt = 0, hold_cnt = 0;
  bit  prev_send = 0, sent_flag = 0, rd_flag = 0, rdy_flag = 0;

  // observe DUT outputs mid-cycle
  always @(negedge i_clk) begin
    cyc++;
    if (o_tx_send) begin
      if (i_tx_active) clash++;
      if (prev_send) wide++;
      if (done_cyc >= 0 && (cyc - done_cyc) < min_gap) min_gap = cyc - done_cyc;
      tx_log.push_back(o_tx_byte);
      sent_flag = 1;
    end
    prev_send = o_tx_send;
    if (o_a_rd_en) begin rd_cnt++;  rd_flag  = 1; end
    if (o_b_ready) begin rdy_cnt++; rdy_flag = 1; end
  end

  // FIFO, B source and uart_tx models drive just after the clock edge
  always @(posedge i_clk) begin
    #1;
    if (i_rst) begin
      i_tx_active = 0; i_tx_done = 0; busy_cnt = 0; hold_cnt = 0;
      sent_flag = 0; rd_flag = 0; rdy_flag = 0;
    end else begin
      if (rd_flag) begin
        if (a_q.size() > 0) i_a_data = a_q.pop_front();
        rd_flag = 0;
      end
      if (rdy_flag) begin i_b_valid = 0; rdy_flag = 0; end
      i_tx_done = 0;
      if (sent_flag) begin
        sent_flag = 0; i_tx_active = 1; busy_cnt = BYTE_CYC;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          i_tx_done = 1; done_cyc = cyc;
          if (hold_len == 0) i_tx_active = 0;
          else hold_cnt = hold_len;
        end
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) i_tx_active = 0;
      end
    end
    i_a_empty = (a_q.size() == 0);
  end

  task automatic tick();
    @(posedge i_clk); #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_to(input string nm, input int k);
    total++;
    if (k >= LIM) begin
      bad++;
      $display("FAIL %s: timed out after %0d cycles, wanted completion", nm, k);
    end
  endtask

  task automatic wait_bytes(input int n, input string nm);
    int k = 0;
    while ((tx_log.size() < n || o_busy) && k < LIM) begin tick(); k++; end
    chk_to(nm, k);
  endtask

  task automatic do_reset();
    i_rst = 1; i_enable = 0; i_b_valid = 0; hold_len = 0;
    a_q.delete();
    repeat (3) tick();
    tx_log.delete(); exp_q.delete();
    rd_cnt = 0; rdy_cnt = 0; done_cyc = -1; min_gap = 1000000;
    i_rst = 0;
    tick();
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] h, input logic [31:0] w);
    return h ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  // reference frame: header, word MSB first, optional checksum
  function automatic void add_frame(input logic [7:0] h, input logic [31:0] w);
    exp_q.push_back(h);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
    if (FLEN == 6) exp_q.push_back(xsum(h, w));
  endfunction

  task automatic cmp_log(input string nm);
    chk({nm, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk($sformatf("%s_byte%0d", nm, i), 32'(tx_log[i]), 32'(exp_q[i]));
  endtask

  function automatic logic [31:0] outs();
    return 32'({o_a_rd_en, o_b_ready, o_tx_send, o_busy, o_tx_byte, o_frame_cnt_a, o_frame_cnt_b});
  endfunction

  typedef struct {
    bit          is_b;
    logic [31:0] word;
    logic [39:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int   na, p, k, sz;
    bit   bp;
    logic [31:0] bw;
    logic [31:0] aw[$];

    tbl[0] = '{1'b0, 32'h1234ABCD, 40'h49_12_34_AB_CD};
    tbl[1] = '{1'b1, 32'h00000001, 40'h53_00_00_00_01};
    tbl[2] = '{1'b0, 32'hCAFEF00D, 40'h49_CA_FE_F0_0D};
    tbl[3] = '{1'b1, 32'hDEADBEEF, 40'h53_DE_AD_BE_EF};
    tbl[4] = '{1'b0, 32'h00000000, 40'h49_00_00_00_00};
    tbl[5] = '{1'b1, 32'hFFFFFFFF, 40'h53_FF_FF_FF_FF};

    repeat (2) tick();
    chk("reset_outputs", outs(), 32'h0);
    i_rst = 0;
    tick();
    chk("idle_after_reset", outs(), 32'h0);

    // single-frame vectors
    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (tbl[v].is_b) begin i_b_data = tbl[v].word; i_b_valid = 1; end
      else a_q.push_back(tbl[v].word);
      tick(); tick();
      i_enable = 1;
      wait_bytes(FLEN, $sformatf("vec%0d_done", v));
      for (int i = 0; i < 5; i++)
        chk($sformatf("vec%0d_byte%0d", v, i), 32'(tx_log[i]), 32'(tbl[v].exp[(4-i)*8 +: 8]));
`ifdef UART_FRAME_CHKSUM_EN
      chk($sformatf("vec%0d_chksum", v), 32'(tx_log[5]), 32'(xsum(tbl[v].exp[39:32], tbl[v].word)));
`endif
      chk($sformatf("vec%0d_cnt_a", v), 32'(o_frame_cnt_a), tbl[v].is_b ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d_cnt_b", v), 32'(o_frame_cnt_b), tbl[v].is_b ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_rd_en", v), 32'(rd_cnt), tbl[v].is_b ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d_ready", v), 32'(rdy_cnt), tbl[v].is_b ? 32'd1 : 32'd0);
      i_enable = 0;
    end

    // arbitration: first run is the fixed starvation case, rest random
    for (int it = 0; it < 7; it++) begin
      if (it == 0) begin
        na = 5; bp = 1; bw = 32'hDEADBEEF;
      end else begin
        na = $urandom_range(0, 6);
        bp = (na == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bw = $urandom;
      end
      do_reset();
      aw.delete();
      for (int j = 0; j < na; j++) begin aw.push_back($urandom); a_q.push_back(aw[j]); end
      // B waits for min(na, MAXB) A frames, then takes the next slot
      p = (na < MAXB) ? na : MAXB;
      for (int j = 0; j < na; j++) begin
        if (bp && j == p) add_frame(HB, bw);
        add_frame(HA, aw[j]);
      end
      if (bp && p == na) add_frame(HB, bw);
      i_b_data = bw; i_b_valid = bp;
      tick(); tick();
      i_enable = 1;
      wait_bytes(exp_q.size(), $sformatf("arb%0d_done", it));
      cmp_log($sformatf("arb%0d", it));
      chk($sformatf("arb%0d_cnt_a", it), 32'(o_frame_cnt_a), 32'(na % 8));
      chk($sformatf("arb%0d_cnt_b", it), 32'(o_frame_cnt_b), 32'(bp));
      chk($sformatf("arb%0d_rd_en", it), 32'(rd_cnt), 32'(na));
      chk($sformatf("arb%0d_ready", it), 32'(rdy_cnt), 32'(bp));
      i_enable = 0;
    end

    // counter wrap: 9 frames on a 3-bit counter
    do_reset();
    for (int j = 0; j < 9; j++) a_q.push_back(32'h100 + j);
    tick(); tick();
    i_enable = 1;
    wait_bytes(9 * FLEN, "wrap_done");
    chk("wrap_cnt_a", 32'(o_frame_cnt_a), 32'd1);
    chk("wrap_rd_en", 32'(rd_cnt), 32'd9);
    i_enable = 0;

    // enable drop after the 2nd byte
    do_reset();
    for (int j = 0; j < 4; j++) a_q.push_back(32'hA0B0C0D0 + j);
    tick(); tick();
    i_enable = 1;
    k = 0;
    while (tx_log.size() < 2 && k < LIM) begin tick(); k++; end
    chk_to("endrop_two_bytes", k);
    i_enable = 0;
    k = 0;
    while (o_busy && k < LIM) begin tick(); k++; end
    chk_to("endrop_idle", k);
    chk("endrop_bytes", 32'(tx_log.size()), 32'(FLEN));
    chk("endrop_cnt_a", 32'(o_frame_cnt_a), 32'd1);
    repeat (30) tick();
    chk("endrop_rd_held", 32'(rd_cnt), 32'd1);
    chk("endrop_busy", 32'(o_busy), 32'd0);
    i_enable = 1;
    wait_bytes(4 * FLEN, "endrop_resume");
    chk("endrop_cnt_a_final", 32'(o_frame_cnt_a), 32'd4);
    chk("endrop_rd_final", 32'(rd_cnt), 32'd4);
    i_enable = 0;

    // reset during the 3rd byte's WAIT
    do_reset();
    a_q.push_back(32'h11223344);
    tick(); tick();
    i_enable = 1;
    k = 0;
    while (tx_log.size() < 3 && k < LIM) begin tick(); k++; end
    chk_to("mrst_third_byte", k);
    i_rst = 1;
    #1;
    chk("mrst_outputs", outs(), 32'h0);
    sz = tx_log.size();
    p  = rd_cnt + rdy_cnt;
    repeat (3) tick();
    chk("mrst_no_send", 32'(tx_log.size()), 32'(sz));
    chk("mrst_no_strobes", 32'(rd_cnt + rdy_cnt), 32'(p));
    chk("mrst_outputs_held", outs(), 32'h0);
    tx_log.delete(); exp_q.delete(); rd_cnt = 0;
    a_q.push_back(32'hCAFEF00D);
    add_frame(HA, 32'hCAFEF00D);
    i_rst = 0;
    wait_bytes(FLEN, "mrst_recover");
    cmp_log("mrst");
    chk("mrst_cnt_a", 32'(o_frame_cnt_a), 32'd1);
    i_enable = 0;

    // transmitter stays busy 50 cycles after every done pulse
    do_reset();
    hold_len = 50;
    a_q.push_back(32'h5A5AA5A5);
    add_frame(HA, 32'h5A5AA5A5);
    tick(); tick();
    i_enable = 1;
    wait_bytes(FLEN, "hs_done");
    cmp_log("hs");
    chk("hs_gap_ge50", 32'(min_gap >= 50), 32'd1);
    i_enable = 0;
    hold_len = 0;

    chk("send_while_active", 32'(clash), 32'd0);
    chk("send_width", 32'(wide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, wanted finish");
    $fatal(1, "global timeout");
  end
endmodule
